// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and byte payload type for the HD44780 time writer.
package lcd_pkg;

    localparam int unsigned CNT_W = 20;
    localparam int unsigned IDX_W = 4;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_HOME     = 8'h80;

    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_DASH  = 8'h2D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_A     = 8'h41;
    localparam logic [7:0] CH_B     = 8'h42;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    typedef enum logic [1:0] {ST_POWERON, ST_INIT, ST_IDLE, ST_FRAME} lcd_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_PULSE, TX_WAIT} tx_state_t;

    typedef struct packed {
        logic             rs;
        logic [7:0]       data;
        logic [CNT_W-1:0] wait_cyc;
    } lcd_byte_t;

    // BCD digit to ASCII; out-of-range codes render as '-'
    function automatic logic [7:0] bcd_char(input logic [3:0] x);
        return (x <= 4'd9) ? (CH_ZERO + {4'h0, x}) : CH_DASH;
    endfunction

endpackage

// File: rtl/lcd_time_writer_if.sv
// HD44780 8-bit parallel bus as seen from the controller (master) and the panel (slave).
interface lcd_time_writer_if;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;

    modport master (output lcd_rs, lcd_rw, lcd_e, lcd_data);
    modport slave  (input  lcd_rs, lcd_rw, lcd_e, lcd_data);
endinterface

// File: rtl/lcd_byte_tx.sv
// One HD44780 byte write: setup cycle, E_PULSE_CYC enable-high cycles, then wait_cyc idle cycles.
// done_c marks the last wait cycle so the caller can chain the next byte with no gap.
module lcd_byte_tx
    import lcd_pkg::*;
#(
    parameter int unsigned E_PULSE_CYC = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             rs,
    input  logic [7:0]       data_in,
    input  logic [CNT_W-1:0] wait_cyc,
    output logic             lcd_rs,
    output logic             lcd_e,
    output logic [7:0]       lcd_data,
    output logic             done_c
);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] wait_q;
    logic             load;

    assign done_c = (state == TX_WAIT) && (cnt == wait_q - CNT_W'(1));
    assign load   = start && ((state == TX_IDLE) || done_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= TX_IDLE;
            cnt      <= '0;
            wait_q   <= '0;
            lcd_rs   <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_data <= 8'h00;
        end else if (load) begin
            // rs/data latched here stay put until the next load
            state    <= TX_SETUP;
            cnt      <= '0;
            wait_q   <= wait_cyc;
            lcd_rs   <= rs;
            lcd_data <= data_in;
            lcd_e    <= 1'b0;
        end else begin
            case (state)
                TX_SETUP: begin
                    lcd_e <= 1'b1;
                    cnt   <= '0;
                    state <= TX_PULSE;
                end
                TX_PULSE: begin
                    if (cnt == CNT_W'(E_PULSE_CYC - 1)) begin
                        lcd_e <= 1'b0;
                        cnt   <= '0;
                        state <= TX_WAIT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                TX_WAIT: begin
                    if (done_c) begin
                        state <= TX_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_time_writer.sv
// Chess-clock time writer: power-on wait, HD44780 init, then rewrites "MM:SS" whenever the digits change.
// Build option PLAYER_TAG_EN prefixes the frame with the active player letter and a space.
module lcd_time_writer
    import lcd_pkg::*;
#(
    parameter int unsigned POWERON_CYC    = 750000,
    parameter int unsigned E_PULSE_CYC    = 12,
    parameter int unsigned CHAR_WAIT_CYC  = 2500,
    parameter int unsigned CLEAR_WAIT_CYC = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          m,
    input  logic [3:0]          c,
    input  logic [3:0]          d,
    input  logic [3:0]          u,
    input  logic                jugador,
    lcd_time_writer_if.master   lcd,
    output logic                ready,
    output logic                frame_done
);

    localparam int unsigned INIT_LEN = 4;
`ifdef PLAYER_TAG_EN
    localparam int unsigned FRAME_LEN = 8;
`else
    localparam int unsigned FRAME_LEN = 6;
`endif

    lcd_state_t       state;
    logic [CNT_W-1:0] pon_cnt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic [3:0]       snap_m, snap_c, snap_d, snap_u;
    logic             changed;
    logic             start_c;
    lcd_byte_t        nxt_c;
    logic             done_c;
    logic             tx_rs, tx_e;
    logic [7:0]       tx_data;

`ifdef PLAYER_TAG_EN
    logic snap_j;
    assign changed = ({m, c, d, u, jugador} != {snap_m, snap_c, snap_d, snap_u, snap_j});
`else
    logic unused_jugador;
    assign unused_jugador = jugador;
    assign changed = ({m, c, d, u} != {snap_m, snap_c, snap_d, snap_u});
`endif

    // Index of the byte the transmitter will take at the coming edge
    assign idx_next = done_c ? (idx + IDX_W'(1)) : idx;

    always_comb begin
        start_c       = 1'b0;
        nxt_c.rs      = 1'b0;
        nxt_c.data    = 8'h00;
        nxt_c.wait_cyc = CNT_W'(CHAR_WAIT_CYC);
        case (state)
            ST_INIT: begin
                start_c = (idx_next < IDX_W'(INIT_LEN));
                case (idx_next)
                    4'd0:    nxt_c.data = CMD_FUNC_SET;
                    4'd1:    nxt_c.data = CMD_DISP_ON;
                    4'd2:    nxt_c.data = CMD_CLEAR;
                    default: nxt_c.data = CMD_ENTRY;
                endcase
                if (nxt_c.data == CMD_CLEAR) begin
                    nxt_c.wait_cyc = CNT_W'(CLEAR_WAIT_CYC);
                end
            end
            ST_FRAME: begin
                start_c  = (idx_next < IDX_W'(FRAME_LEN));
                nxt_c.rs = (idx_next != '0);
                case (idx_next)
`ifdef PLAYER_TAG_EN
                    4'd0:    nxt_c.data = CMD_HOME;
                    4'd1:    nxt_c.data = snap_j ? CH_B : CH_A;
                    4'd2:    nxt_c.data = CH_SPACE;
                    4'd3:    nxt_c.data = bcd_char(snap_m);
                    4'd4:    nxt_c.data = bcd_char(snap_c);
                    4'd5:    nxt_c.data = CH_COLON;
                    4'd6:    nxt_c.data = bcd_char(snap_d);
                    default: nxt_c.data = bcd_char(snap_u);
`else
                    4'd0:    nxt_c.data = CMD_HOME;
                    4'd1:    nxt_c.data = bcd_char(snap_m);
                    4'd2:    nxt_c.data = bcd_char(snap_c);
                    4'd3:    nxt_c.data = CH_COLON;
                    4'd4:    nxt_c.data = bcd_char(snap_d);
                    default: nxt_c.data = bcd_char(snap_u);
`endif
                endcase
            end
            default: ;
        endcase
    end

    lcd_byte_tx #(
        .E_PULSE_CYC (E_PULSE_CYC)
    ) u_byte_tx (
        .clk      (clk),
        .reset    (reset),
        .start    (start_c),
        .rs       (nxt_c.rs),
        .data_in  (nxt_c.data),
        .wait_cyc (nxt_c.wait_cyc),
        .lcd_rs   (tx_rs),
        .lcd_e    (tx_e),
        .lcd_data (tx_data),
        .done_c   (done_c)
    );

    assign lcd.lcd_rs   = tx_rs;
    assign lcd.lcd_e    = tx_e;
    assign lcd.lcd_data = tx_data;
    assign lcd.lcd_rw   = 1'b0;

    // Sequencer: the frame is built only from the snapshot taken on entry to FRAME
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_POWERON;
            pon_cnt    <= '0;
            idx        <= '0;
            snap_m     <= '0;
            snap_c     <= '0;
            snap_d     <= '0;
            snap_u     <= '0;
`ifdef PLAYER_TAG_EN
            snap_j     <= 1'b0;
`endif
            ready      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_POWERON: begin
                    if (pon_cnt == CNT_W'(POWERON_CYC - 1)) begin
                        pon_cnt <= '0;
                        idx     <= '0;
                        state   <= ST_INIT;
                    end else begin
                        pon_cnt <= pon_cnt + CNT_W'(1);
                    end
                end
                ST_INIT: begin
                    if (done_c) begin
                        if (idx == IDX_W'(INIT_LEN - 1)) begin
                            ready  <= 1'b1;
                            idx    <= '0;
                            snap_m <= m;
                            snap_c <= c;
                            snap_d <= d;
                            snap_u <= u;
`ifdef PLAYER_TAG_EN
                            snap_j <= jugador;
`endif
                            state  <= ST_FRAME;
                        end else begin
                            idx <= idx_next;
                        end
                    end
                end
                ST_IDLE: begin
                    if (changed) begin
                        idx    <= '0;
                        snap_m <= m;
                        snap_c <= c;
                        snap_d <= d;
                        snap_u <= u;
`ifdef PLAYER_TAG_EN
                        snap_j <= jugador;
`endif
                        state  <= ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    if (done_c) begin
                        if (idx == IDX_W'(FRAME_LEN - 1)) begin
                            frame_done <= 1'b1;
                            idx        <= '0;
                            state      <= ST_IDLE;
                        end else begin
                            idx <= idx_next;
                        end
                    end
                end
                default: state <= ST_POWERON;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_time_writer.sv
// Scoreboard bench for lcd_time_writer: stimulus pushes expected bus bytes, a negedge monitor pops and checks them.
module tb_lcd_time_writer;

    localparam int unsigned POWERON_CYC    = 20;
    localparam int unsigned E_PULSE_CYC    = 2;
    localparam int unsigned CHAR_WAIT_CYC  = 5;
    localparam int unsigned CLEAR_WAIT_CYC = 10;
    localparam int          BUDGET         = 3000;

    typedef struct {
        logic [8:0] b;
        int         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] m, c, d, u;
    logic       jugador;
    logic       ready, frame_done;

    lcd_time_writer_if lcd_bus ();

    lcd_time_writer #(
        .POWERON_CYC    (POWERON_CYC),
        .E_PULSE_CYC    (E_PULSE_CYC),
        .CHAR_WAIT_CYC  (CHAR_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m          (m),
        .c          (c),
        .d          (d),
        .u          (u),
        .jugador    (jugador),
        .lcd        (lcd_bus),
        .ready      (ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t ex;
    int   n_cmp = 0;
    int   n_err = 0;
    int   fd_cnt = 0;
    int   rise_cnt = 0;
    int   since_rst = 0;
    int   hi = 0;
    int   gap = 0;
    logic e_prev = 1'b0;
    logic fd_prev = 1'b0;
    logic started = 1'b0;
    logic [8:0] cap = '0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endfunction

    function automatic void push(input logic rs, input logic [7:0] b, input int g);
        exp_t t;
        t.b   = {rs, b};
        t.gap = g;
        exp_q.push_back(t);
    endfunction

    // Init command bytes; the gap is low-e cycles before a byte (wait + setup)
    function automatic void push_init();
        push(1'b0, 8'h38, 0);
        push(1'b0, 8'h0C, 6);
        push(1'b0, 8'h01, 6);
        push(1'b0, 8'h06, 11);
    endfunction

    function automatic void push_frame(input logic [7:0] tag, input logic [7:0] c0, input logic [7:0] c1,
                                       input logic [7:0] c2, input logic [7:0] c3);
        push(1'b0, 8'h80, 0);
`ifdef PLAYER_TAG_EN
        push(1'b1, tag, 6);
        push(1'b1, 8'h20, 6);
`else
        if (tag == 8'hFF) push(1'b1, tag, 6);
`endif
        push(1'b1, c0, 6);
        push(1'b1, c1, 6);
        push(1'b1, 8'h3A, 6);
        push(1'b1, c2, 6);
        push(1'b1, c3, 6);
    endfunction

    // Monitor: samples the bus on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            e_prev    = 1'b0;
            fd_prev   = 1'b0;
            hi        = 0;
            gap       = 0;
            since_rst = 0;
            started   = 1'b0;
        end else begin
            since_rst++;
            if (frame_done) begin
                check("frame_done_single", 32'(fd_prev), 32'd0);
                fd_cnt++;
            end
            fd_prev = frame_done;
            if (lcd_bus.lcd_e && !e_prev) begin
                rise_cnt++;
                if (!started) begin
                    check("poweron_wait", 32'(since_rst > POWERON_CYC), 32'd1);
                    started = 1'b1;
                end
                check("rw_low", 32'(lcd_bus.lcd_rw), 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_byte: got rs=%0b data=%02h, expected no byte (t=%0t)",
                             lcd_bus.lcd_rs, lcd_bus.lcd_data, $time);
                end else begin
                    ex = exp_q.pop_front();
                    check("byte", 32'({lcd_bus.lcd_rs, lcd_bus.lcd_data}), 32'(ex.b));
                    if (ex.gap != 0) check("byte_gap", 32'(gap), 32'(ex.gap));
                    if (ex.b == 9'h006) check("ready_before_entry", 32'(ready), 32'd0);
                end
                cap = {lcd_bus.lcd_rs, lcd_bus.lcd_data};
                hi  = 1;
            end else if (lcd_bus.lcd_e) begin
                hi++;
                check("hold_stable", 32'({lcd_bus.lcd_rs, lcd_bus.lcd_data}), 32'(cap));
            end else if (e_prev) begin
                check("e_width", 32'(hi), 32'(E_PULSE_CYC));
                gap = 1;
            end else begin
                gap++;
            end
            e_prev = lcd_bus.lcd_e;
        end
    end

    task automatic set_in(input logic [3:0] nm, input logic [3:0] nc, input logic [3:0] nd,
                          input logic [3:0] nu, input logic nj);
        @(posedge clk);
        #1;
        m = nm; c = nc; d = nd; u = nu; jugador = nj;
    endtask

    task automatic wait_fd(input int target, input string name);
        int t = 0;
        while (fd_cnt < target && t < BUDGET) begin
            @(posedge clk);
            t++;
        end
        check(name, 32'(fd_cnt >= target), 32'd1);
    endtask

    task automatic wait_rise(input int target, input string name);
        int t = 0;
        while (rise_cnt < target && t < BUDGET) begin
            @(posedge clk);
            t++;
        end
        check(name, 32'(rise_cnt >= target), 32'd1);
    endtask

    task automatic quiet(input int cycles, input string name);
        int r0 = rise_cnt;
        int f0 = fd_cnt;
        repeat (cycles) @(posedge clk);
        check(name, 32'(rise_cnt - r0), 32'd0);
        check({name, "_fd"}, 32'(fd_cnt - f0), 32'd0);
    endtask

    initial begin
        int base;
        int fd0;
        reset = 1'b1;
        m = 4'd0; c = 4'd5; d = 4'd0; u = 4'd0; jugador = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({lcd_bus.lcd_e, lcd_bus.lcd_rs, lcd_bus.lcd_rw, lcd_bus.lcd_data, ready, frame_done}), 32'd0);

        // Power-on, init and the first unconditional frame "05:00"
        push_init();
        push_frame(8'h41, 8'h30, 8'h35, 8'h30, 8'h30);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_in_poweron", 32'(ready), 32'd0);
        wait_fd(1, "first_frame_done");
        check("ready_after_init", 32'(ready), 32'd1);
        check("first_frame_count", 32'(fd_cnt), 32'd1);
        quiet(40, "stable_idle");

        // u 0->9, then 9->8 while the frame is still being written
        fd0  = fd_cnt;
        base = rise_cnt;
        push_frame(8'h41, 8'h30, 8'h35, 8'h30, 8'h39);
        push_frame(8'h41, 8'h30, 8'h35, 8'h30, 8'h38);
        set_in(4'd0, 4'd5, 4'd0, 4'd9, 1'b0);
        wait_rise(base + 3, "reach_third_byte");
        #1 u = 4'd8;
        wait_fd(fd0 + 2, "two_frames_done");
        check("two_frames_count", 32'(fd_cnt - fd0), 32'd2);
        quiet(30, "stable_after_update");

        // Out-of-range BCD digit renders as '-'
        fd0 = fd_cnt;
        push_frame(8'h41, 8'h30, 8'h35, 8'h2D, 8'h38);
        set_in(4'd0, 4'd5, 4'hC, 4'd8, 1'b0);
        wait_fd(fd0 + 1, "dash_frame_done");

        // Digit boundaries 9 and 0xA together
        fd0 = fd_cnt;
        push_frame(8'h41, 8'h2D, 8'h39, 8'h2D, 8'h38);
        set_in(4'hA, 4'd9, 4'hC, 4'd8, 1'b0);
        wait_fd(fd0 + 1, "boundary_frame_done");

`ifdef PLAYER_TAG_EN
        fd0 = fd_cnt;
        push_frame(8'h42, 8'h2D, 8'h39, 8'h2D, 8'h38);
        set_in(4'hA, 4'd9, 4'hC, 4'd8, 1'b1);
        wait_fd(fd0 + 1, "tag_frame_done");
        check("tag_frame_count", 32'(fd_cnt - fd0), 32'd1);
`else
        set_in(4'hA, 4'd9, 4'hC, 4'd8, 1'b1);
        quiet(40, "jugador_ignored");
`endif

        // Reset during the e-high phase of a character aborts and replays init
        base = rise_cnt;
        push_frame(8'h41, 8'h2D, 8'h39, 8'h2D, 8'h37);
        set_in(4'hA, 4'd9, 4'hC, 4'd7, jugador);
        wait_rise(base + 2, "reach_char_pulse");
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_e", 32'(lcd_bus.lcd_e), 32'd0);
        check("abort_data", 32'(lcd_bus.lcd_data), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        exp_q.delete();
        push_init();
`ifdef PLAYER_TAG_EN
        push_frame(8'h42, 8'h2D, 8'h39, 8'h2D, 8'h37);
`else
        push_frame(8'h41, 8'h2D, 8'h39, 8'h2D, 8'h37);
`endif
        fd0 = fd_cnt;
        @(posedge clk);
        #1 reset = 1'b0;
        wait_fd(fd0 + 1, "replay_frame_done");
        check("replay_ready", 32'(ready), 32'd1);
        quiet(30, "stable_after_replay");

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
